// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: requester handshakes, register file write port and
// register file read ports (raw in, bypassed out) bundled in one interface.
// The arbiter connects to the slave modport; the requester/regfile side uses master.
interface regfile_wb_arbiter_if #(
   parameter int N_REQ    = 3,
   parameter int N_RPORTS = 2,
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
);
   localparam int AW = $clog2(NUM_REGS);

   logic [N_REQ-1:0]                i_req_valid;
   logic [N_REQ-1:0]                o_req_ready;
   logic [N_REQ-1:0][AW-1:0]        i_req_addr;
   logic [N_REQ-1:0][XLEN-1:0]      i_req_data;

   logic                            o_rf_we;
   logic [AW-1:0]                   o_rf_waddr;
   logic [XLEN-1:0]                 o_rf_wdata;

   logic [N_RPORTS-1:0][AW-1:0]     i_raddr;
   logic [N_RPORTS-1:0][XLEN-1:0]   i_rf_rdata;
   logic [N_RPORTS-1:0][XLEN-1:0]   o_rdata;

   modport master (
      output i_req_valid, i_req_addr, i_req_data, i_raddr, i_rf_rdata,
      input  o_req_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_rdata
   );

   modport slave (
      input  i_req_valid, i_req_addr, i_req_data, i_raddr, i_rf_rdata,
      output o_req_ready, o_rf_we, o_rf_waddr, o_rf_wdata, o_rdata
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the integer register file.
// Shares the single write port among N_REQ sources through a one-entry write
// stage; writes to x0 are accepted and dropped.
// Optional feature: define COTM32_WB_BYPASS_EN to forward the staged write to
// the read ports; without it o_rdata is the raw register file data.
module regfile_wb_arbiter #(
   parameter int N_REQ    = 3,
   parameter int N_RPORTS = 2,
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_stall,
   regfile_wb_arbiter_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]    ptr_q, ptr_d;
   logic             stg_valid_q, stg_valid_d;
   logic [AW-1:0]    stg_addr_q, stg_addr_d;
   logic [XLEN-1:0]  stg_data_q, stg_data_d;

   logic [N_REQ-1:0] grant;
   logic [PW-1:0]    grant_idx;
   logic             grant_any;
   logic             xfer;
   logic [AW-1:0]    sel_addr;
   logic [XLEN-1:0]  sel_data;
   logic             stg_live;

   // (base + off) mod N_REQ for base, off < N_REQ.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= unsigned'(N_REQ)) sum = sum - unsigned'(N_REQ);
      return sum[PW-1:0];
   endfunction

   // Pick the first valid requester at or after the round-robin pointer.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_any && bus.i_req_valid[wrap_add(ptr_q, k)]) begin
            grant_any = 1'b1;
            grant_idx = wrap_add(ptr_q, k);
         end
      end
      grant[grant_idx] = grant_any;
   end

   assign bus.o_req_ready = grant & {N_REQ{~i_stall & ~i_rst}};
   assign xfer            = grant_any & ~i_stall & ~i_rst;
   assign sel_addr        = bus.i_req_addr[grant_idx];
   assign sel_data        = bus.i_req_data[grant_idx];

   // Next state: advance the pointer past the winner and stage non-x0 writes.
   always_comb begin
      ptr_d       = ptr_q;
      stg_valid_d = 1'b0;
      stg_addr_d  = stg_addr_q;
      stg_data_d  = stg_data_q;
      if (xfer) begin
         ptr_d = wrap_add(grant_idx, 1);
         if (sel_addr != '0) begin
            stg_valid_d = 1'b1;
            stg_addr_d  = sel_addr;
            stg_data_d  = sel_data;
         end
      end
   end

   // Pointer and write stage registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (i_rst) begin
         ptr_q       <= '0;
         stg_valid_q <= 1'b0;
         stg_addr_q  <= '0;
         stg_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         stg_valid_q <= stg_valid_d;
         stg_addr_q  <= stg_addr_d;
         stg_data_q  <= stg_data_d;
      end
   end

   // A write still staged when reset arrives must not reach the register file
   // at the reset edge, so the enable is masked by reset.
   assign stg_live       = stg_valid_q & ~i_rst;
   assign bus.o_rf_we    = stg_live;
   assign bus.o_rf_waddr = stg_addr_q;
   assign bus.o_rf_wdata = stg_data_q;

`ifdef COTM32_WB_BYPASS_EN
   // Forward the staged write to read ports addressing it, covering the cycle before commit.
   always_comb begin
      for (int p = 0; p < N_RPORTS; p++) begin
         bus.o_rdata[p] = (stg_live && (stg_addr_q == bus.i_raddr[p])) ? stg_data_q
                                                                       : bus.i_rf_rdata[p];
      end
   end
`else
   assign bus.o_rdata = bus.i_rf_rdata;

   logic unused_raddr;
   assign unused_raddr = ^bus.i_raddr;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a register file model sits on the
// write port, expected writes are queued as stimulus is driven and compared as
// the write port fires.
module tb_regfile_wb_arbiter;
   localparam int N_REQ    = 3;
   localparam int N_RPORTS = 2;
   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk;
   logic rst;
   logic stall;

   int n_tests = 0;
   int n_fail  = 0;

   wr_t exp_q[$];
   logic [31:0] rf [NUM_REGS];

   regfile_wb_arbiter_if #(
      .N_REQ(N_REQ), .N_RPORTS(N_RPORTS), .XLEN(XLEN), .NUM_REGS(NUM_REGS)
   ) bus ();

   regfile_wb_arbiter #(
      .N_REQ(N_REQ), .N_RPORTS(N_RPORTS), .XLEN(XLEN), .NUM_REGS(NUM_REGS)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_stall (stall),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model on the write port.
   initial for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
   always @(posedge clk) if (bus.o_rf_we === 1'b1) rf[bus.o_rf_waddr] <= bus.o_rf_wdata;
   assign bus.i_rf_rdata[0] = rf[bus.i_raddr[0]];
   assign bus.i_rf_rdata[1] = rf[bus.i_raddr[1]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write seen on the port must match the oldest expected one.
   always @(negedge clk) begin
      #2;
      if (bus.o_rf_we !== 1'b0) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_write", {27'd0, bus.o_rf_waddr, bus.o_rf_wdata}, 64'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("sb_waddr", 64'(bus.o_rf_waddr), 64'(e.addr));
            check("sb_wdata", 64'(bus.o_rf_wdata), 64'(e.data));
         end
      end
   end

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   initial begin
      logic [31:0] rr_data [3];
      logic [31:0] exp_bypass;
      logic [31:0] exp_x5;
      rr_data[0] = 32'h11111111;
      rr_data[1] = 32'h22222222;
      rr_data[2] = 32'h33333333;

      // Reset held for two cycles with every requester valid.
      rst   = 1'b1;
      stall = 1'b0;
      bus.i_req_valid = 3'b111;
      for (int i = 0; i < N_REQ; i++) begin
         bus.i_req_addr[i] = 5'(i + 1);
         bus.i_req_data[i] = rr_data[i];
      end
      bus.i_raddr[0] = '0;
      bus.i_raddr[1] = '0;

      @(negedge clk); #1;
      check("rst_ready_c1", 64'(bus.o_req_ready), 64'd0);
      check("rst_we_c1", 64'(bus.o_rf_we), 64'd0);
      @(negedge clk); #1;
      check("rst_ready_c2", 64'(bus.o_req_ready), 64'd0);
      check("rst_we_c2", 64'(bus.o_rf_we), 64'd0);
      check("rst_waddr", 64'(bus.o_rf_waddr), 64'd0);
      check("rst_wdata", 64'(bus.o_rf_wdata), 64'd0);

      // Round robin: grants 0,1,2,0,1,2 one per cycle, write port busy after the first.
      rst = 1'b0;
      #1;
      for (int i = 0; i < 6; i++) begin
         check("rr_ready", 64'(bus.o_req_ready), 64'(3'b001 << (i % 3)));
         check("rr_we", 64'(bus.o_rf_we), (i > 0) ? 64'd1 : 64'd0);
         push(5'(i % 3 + 1), rr_data[i % 3]);
         @(negedge clk); #1;
      end

      // x0 drop: req1 writes x0, accepted but never reaches the write port.
      bus.i_req_valid   = 3'b010;
      bus.i_req_addr[1] = 5'd0;
      bus.i_req_data[1] = 32'hccddeeff;
      #1;
      check("x0_ready", 64'(bus.o_req_ready), 64'b010);

      // Pointer now at 2: with req0 and req2 valid, req2 wins first.
      @(negedge clk);
      bus.i_req_valid   = 3'b101;
      bus.i_req_addr[0] = 5'd4;
      bus.i_req_data[0] = 32'h44444444;
      bus.i_req_addr[2] = 5'd6;
      bus.i_req_data[2] = 32'h66666666;
      #1;
      check("x0_no_write", 64'(bus.o_rf_we), 64'd0);
      check("x0_ptr_grant", 64'(bus.o_req_ready), 64'b100);
      push(5'd6, 32'h66666666);

      @(negedge clk);
      bus.i_req_valid = 3'b001;
      #1;
      check("after_x0_ready", 64'(bus.o_req_ready), 64'b001);
      push(5'd4, 32'h44444444);

      // Stall: req0 holds x5 for three stalled cycles without being accepted.
      @(negedge clk);
      bus.i_req_addr[0] = 5'd5;
      bus.i_req_data[0] = 32'habcdef00;
      stall = 1'b1;
      #1;
      check("stall_ready_c1", 64'(bus.o_req_ready), 64'd0);
      @(negedge clk); #1;
      check("stall_ready_c2", 64'(bus.o_req_ready), 64'd0);
      check("stall_we_c2", 64'(bus.o_rf_we), 64'd0);
      @(negedge clk); #1;
      check("stall_ready_c3", 64'(bus.o_req_ready), 64'd0);
      check("stall_we_c3", 64'(bus.o_rf_we), 64'd0);

      @(negedge clk);
      stall = 1'b0;
      bus.i_raddr[1] = 5'd5;
      #1;
      check("stall_release_ready", 64'(bus.o_req_ready), 64'b001);
      check("x5_before", 64'(bus.o_rdata[1]), 64'd0);
      push(5'd5, 32'habcdef00);

      // x5 staged this cycle; first write of x15 by req1.
      @(negedge clk);
      bus.i_req_valid   = 3'b010;
      bus.i_req_addr[1] = 5'd15;
      bus.i_req_data[1] = 32'hdeadbeef;
`ifdef COTM32_WB_BYPASS_EN
      exp_x5 = 32'habcdef00;
`else
      exp_x5 = 32'h0;
`endif
      #1;
      check("x5_staged_read", 64'(bus.o_rdata[1]), 64'(exp_x5));
      check("x15_a_ready", 64'(bus.o_req_ready), 64'b010);
      push(5'd15, 32'hdeadbeef);

      @(negedge clk);
      bus.i_req_data[1] = 32'h12345600;
      #1;
      check("x5_committed", 64'(bus.o_rdata[1]), 64'habcdef00);
      check("x15_b_ready", 64'(bus.o_req_ready), 64'b010);
      push(5'd15, 32'h12345600);

      // Bypass window: x15 = 12345600 staged, register file still holds deadbeef.
      @(negedge clk);
      bus.i_req_valid = 3'b000;
      bus.i_raddr[0]  = 5'd15;
`ifdef COTM32_WB_BYPASS_EN
      exp_bypass = 32'h12345600;
`else
      exp_bypass = 32'hdeadbeef;
`endif
      #1;
      check("bypass_window", 64'(bus.o_rdata[0]), 64'(exp_bypass));

      @(negedge clk);
      #1;
      check("x15_committed", 64'(bus.o_rdata[0]), 64'h12345600);

      // Mid-operation reset: x2 = 1 is transferred, then reset discards it.
      bus.i_req_valid   = 3'b100;
      bus.i_req_addr[2] = 5'd2;
      bus.i_req_data[2] = 32'h00000001;
      #1;
      check("midrst_xfer_ready", 64'(bus.o_req_ready), 64'b100);

      @(negedge clk);
      rst = 1'b1;
      bus.i_req_valid = 3'b000;
      bus.i_raddr[0]  = 5'd2;
      #1;
      check("midrst_we", 64'(bus.o_rf_we), 64'd0);
      check("midrst_ready", 64'(bus.o_req_ready), 64'd0);

      @(negedge clk);
      rst = 1'b0;
      bus.i_req_valid   = 3'b110;
      bus.i_req_addr[1] = 5'd7;
      bus.i_req_data[1] = 32'h77777777;
      bus.i_req_addr[2] = 5'd8;
      bus.i_req_data[2] = 32'h88888888;
      #1;
      check("midrst_x2_kept", 64'(bus.o_rdata[0]), 64'h22222222);
      check("postrst_we", 64'(bus.o_rf_we), 64'd0);
      check("postrst_ptr_grant", 64'(bus.o_req_ready), 64'b010);
      push(5'd7, 32'h77777777);

      @(negedge clk);
      bus.i_req_valid = 3'b100;
      #1;
      check("postrst_next_grant", 64'(bus.o_req_ready), 64'b100);
      push(5'd8, 32'h88888888);

      @(negedge clk);
      bus.i_req_valid = 3'b000;
      repeat (3) @(negedge clk);
      #3;
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      check("mid_rst_rf_x2", 64'(rf[2]), 64'h22222222);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the integer register file. It shares the file's single write port among `N_REQ` write-back sources (ALU, load unit, CSR unit, and so on) using a round-robin valid/ready handshake. Each granted write passes through a one-entry registered write stage that drives the register file write port. The block also optionally forwards that staged write to the register file read ports.

## Interface
Parameters:
- `N_REQ`, 3: number of write-back requesters, 2..8.
- `N_RPORTS`, 2: number of register file read ports seen through the bypass path.

Ports:
- `i_clk`  in  1: clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_stall`  in  1: when high, no new grant is issued; the write stage still drains.
- `i_req_valid`  in  [N_REQ]: requester i holds a write.
- `o_req_ready`  out  [N_REQ]: requester i's write is accepted this cycle.
- `i_req_addr`  in  [N_REQ][$clog2(NUM_REGS)]: destination register.
- `i_req_data`  in  [N_REQ][XLEN]: write data.
- `o_rf_we`  out  1: register file write enable.
- `o_rf_waddr`  out  $clog2(NUM_REGS): register file write address.
- `o_rf_wdata`  out  XLEN: register file write data.
- `i_raddr`  in  [N_RPORTS][$clog2(NUM_REGS)]: read addresses, identical to those driven to the register file.
- `i_rf_rdata`  in  [N_RPORTS][XLEN]: raw register file read data.
- `o_rdata`  out  [N_RPORTS][XLEN]: read data as seen by consumers.

## Operation
- State consists of:
  - round-robin pointer `ptr` (0..N_REQ-1);
  - write stage `{stg_valid, stg_addr, stg_data}`.
- Grant rule:
  - `grant` selects the first index i with `i_req_valid[i]`, searching `ptr, ptr+1, …` modulo N_REQ.
  - At most one grant is issued per cycle.
  - `o_req_ready[i] = grant[i] & ~i_stall & ~i_rst`. The ready path is combinational from valid and stall.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - A requester holding valid must keep its addr and data stable until the transfer.
  - Dropping valid before the transfer is illegal.
- On a transfer by requester g:
  - `ptr <= (g+1) mod N_REQ`.
  - If `addr != 0`: `stg_valid <= 1`, `stg_addr <= addr`, `stg_data <= data`.
  - If `addr == 0`: the write is accepted and discarded, `stg_valid <= 0`. The pointer still advances.
- With no transfer: `stg_valid <= 0`, and `ptr` is unchanged.
- The stage always drains because the register file accepts one write per cycle, so throughput is one write per cycle.
- Write port outputs:
  - `o_rf_we = stg_valid`
  - `o_rf_waddr = stg_addr`
  - `o_rf_wdata = stg_data`
- `o_rdata` passthrough/bypass: see Configuration.
- Fairness: a continuously valid requester is granted within N_REQ cycles of raising valid, provided `i_stall` stays low.

## Timing
- Reset values:
  - `ptr = 0`, `stg_valid = 0`, `stg_addr = 0`, `stg_data = 0`.
  - Therefore `o_rf_we = 0`, `o_rf_waddr = 0`, `o_rf_wdata = 0`.
  - `o_req_ready = 0` while `i_rst` is high.
- Reset mid-operation: a staged write is discarded and is never committed to the register file.
- Latency, for a transfer at edge T:
  - `o_rf_we` is high during cycle T..T+1.
  - The register file commits at edge T+1.
  - `i_rf_rdata` reflects the new value from edge T+1 onward.
- Stall: stall asserted in cycle c means no transfer at the end of c. A write already staged still commits.
- Simultaneous requests to the same register: they are serialized in grant order, and the later grant wins in the register file.

## Configuration
- Macro `COTM32_WB_BYPASS_EN`.
- Defined: for each read port p, `o_rdata[p] = stg_data` when `stg_valid && stg_addr == i_raddr[p]`; otherwise `o_rdata[p] = i_rf_rdata[p]`. This closes the one-cycle window before the commit. An address-0 read can never match, because x0 is never staged.
- Undefined: `o_rdata[p] = i_rf_rdata[p]` unconditionally, and `stg_data` drives the write port only.

## Test plan
- Reset check:
  - Stimulus: assert `i_rst` for 2 cycles while all requesters are valid.
  - Response: `o_req_ready = 0` and `o_rf_we = 0`. The first grant after release goes to req0.
- Round-robin:
  - Stimulus: all 3 requesters continuously valid with addrs 1/2/3 and data `32'h11111111` / `32'h22222222` / `32'h33333333`.
  - Response: grants 0, 1, 2, 0, …, one per cycle, and `o_rf_we` high every cycle after the first.
- x0 drop:
  - Stimulus: req1 writes x0 with `32'hccddeeff`.
  - Response: req1 sees ready, `o_rf_we` stays 0 the next cycle, and `ptr` advances to 2.
- Stall:
  - Stimulus: req0 valid with x5 = `32'habcdef00`, `i_stall` high for 3 cycles.
  - Response: no ready during the stall. Ready in the cycle stall drops, and x5 reads `32'habcdef00` 1 cycle later.
- Bypass (macro defined):
  - Stimulus: write x15 = `32'h12345600`, with raddr[0] = 15 in the cycle after the transfer.
  - Response: `o_rdata[0] = 32'h12345600` while `i_rf_rdata[0]` still holds the old value.
  - With the macro undefined: `o_rdata[0]` equals the old value in that cycle.
- Mid-operation reset:
  - Stimulus: transfer x2 = `32'h1`, then assert `i_rst` in the following cycle.
  - Response: no commit; x2 is unchanged.
